// File: rtl/cpu_mem_stage.sv
// cpu_mem_stage: memory stage of the 16-bit five-stage pipeline.
// Takes the EX/MEM register outputs, runs loads and stores over a variable-latency
// ready-handshaked data-memory port, stalls upstream while an access is outstanding,
// and owns the MEM/WB register. A sticky watchdog flags accesses that never complete.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   ex_*                        EX/MEM pipeline register contents
//   mem_req/we/addr/wdata       data-memory request (registered)
//   mem_rdata, mem_ready        data-memory response
//   stall_o                     combinational upstream hold
//   wb_valid/regWrite/writeReg/data   MEM/WB pipeline register
//   mem_timeout                 sticky watchdog flag
module cpu_mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [15:0] ex_aluOut,
    input  logic [15:0] ex_storeData,
    input  logic        ex_memRead,
    input  logic        ex_memWrite,
    input  logic        ex_memToReg,
    input  logic        ex_regWrite,
    input  logic [3:0]  ex_writeReg,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall_o,
    output logic        wb_valid,
    output logic        wb_regWrite,
    output logic [3:0]  wb_writeReg,
    output logic [15:0] wb_data,
    output logic        mem_timeout
);

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 4;
    localparam int unsigned CW = 16;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nx;
    logic          mem_req_nx, mem_we_nx, wb_valid_nx, wb_regwrite_nx, timeout_nx;
    logic [DW-1:0] mem_addr_nx, mem_wdata_nx, wb_data_nx;
    logic [RW-1:0] wb_writereg_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_sat;

    // Writeback controls captured at accept time
    logic          lat_regwrite, lat_regwrite_nx;
    logic          lat_load, lat_load_nx;     // read whose result goes to the register file
    logic [RW-1:0] lat_writereg, lat_writereg_nx;
    logic [DW-1:0] lat_alu, lat_alu_nx;

    logic is_mem;
    logic done;

    assign is_mem  = ex_valid & (ex_memRead | ex_memWrite);
    assign done    = (state == BUSY) & mem_ready;
    assign stall_o = is_mem & ~done;
    assign cnt_sat = (cnt == '1) ? cnt : cnt + CW'(1);

    // Next-state and next-register values
    always_comb begin
        state_nx        = state;
        mem_req_nx      = mem_req;
        mem_we_nx       = mem_we;
        mem_addr_nx     = mem_addr;
        mem_wdata_nx    = mem_wdata;
        timeout_nx      = mem_timeout;
        cnt_nx          = cnt;
        lat_regwrite_nx = lat_regwrite;
        lat_load_nx     = lat_load;
        lat_writereg_nx = lat_writereg;
        lat_alu_nx      = lat_alu;
        // MEM/WB defaults to a bubble
        wb_valid_nx     = 1'b0;
        wb_regwrite_nx  = 1'b0;
        wb_writereg_nx  = '0;
        wb_data_nx      = '0;

        case (state)
            IDLE: begin
                if (is_mem) begin
                    state_nx        = BUSY;
                    mem_req_nx      = 1'b1;
                    mem_we_nx       = ex_memWrite;
                    mem_addr_nx     = {ex_aluOut[DW-1:1], 1'b0};
                    mem_wdata_nx    = ex_storeData;
                    cnt_nx          = '0;
                    lat_regwrite_nx = ex_regWrite;
                    // A write wins when both read and write are set
                    lat_load_nx     = ex_memToReg & ex_memRead & ~ex_memWrite;
                    lat_writereg_nx = ex_writeReg;
                    lat_alu_nx      = ex_aluOut;
                end else if (ex_valid) begin
                    wb_valid_nx    = 1'b1;
                    wb_regwrite_nx = ex_regWrite;
                    wb_writereg_nx = ex_writeReg;
                    wb_data_nx     = ex_aluOut;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_nx       = IDLE;
                    mem_req_nx     = 1'b0;
                    cnt_nx         = '0;
                    wb_valid_nx    = 1'b1;
                    wb_regwrite_nx = lat_regwrite;
                    wb_writereg_nx = lat_writereg;
                    wb_data_nx     = lat_load ? mem_rdata : lat_alu;
                end else begin
                    cnt_nx = cnt_sat;
                    if (cnt_sat >= CW'(TIMEOUT)) begin
                        timeout_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_timeout  <= 1'b0;
            cnt          <= '0;
            wb_valid     <= 1'b0;
            wb_regWrite  <= 1'b0;
            wb_writeReg  <= '0;
            wb_data      <= '0;
            lat_regwrite <= 1'b0;
            lat_load     <= 1'b0;
            lat_writereg <= '0;
            lat_alu      <= '0;
        end else begin
            state        <= state_nx;
            mem_req      <= mem_req_nx;
            mem_we       <= mem_we_nx;
            mem_addr     <= mem_addr_nx;
            mem_wdata    <= mem_wdata_nx;
            mem_timeout  <= timeout_nx;
            cnt          <= cnt_nx;
            wb_valid     <= wb_valid_nx;
            wb_regWrite  <= wb_regwrite_nx;
            wb_writeReg  <= wb_writereg_nx;
            wb_data      <= wb_data_nx;
            lat_regwrite <= lat_regwrite_nx;
            lat_load     <= lat_load_nx;
            lat_writereg <= lat_writereg_nx;
            lat_alu      <= lat_alu_nx;
        end
    end

endmodule

// File: tb/tb_cpu_mem_stage.sv
// Testbench for cpu_mem_stage: vector table, hand-written corner sequences and
// random operations checked against a transaction-level reference model.
module tb_cpu_mem_stage;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_memRead, ex_memWrite, ex_memToReg, ex_regWrite;
    logic [15:0] ex_aluOut, ex_storeData;
    logic [3:0]  ex_writeReg;
    logic        mem_req, mem_we, mem_ready, stall_o;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        wb_valid, wb_regWrite, mem_timeout;
    logic [3:0]  wb_writeReg;
    logic [15:0] wb_data;

    cpu_mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_aluOut(ex_aluOut), .ex_storeData(ex_storeData),
        .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg),
        .ex_regWrite(ex_regWrite), .ex_writeReg(ex_writeReg),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall_o(stall_o),
        .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_writeReg(wb_writeReg),
        .wb_data(wb_data), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, rd, wr, m2r, rw;
        logic [3:0]  wreg;
        logic [15:0] alu, sd, rdata;
        int          waits;        // cycles mem_ready is withheld
        logic        exp_valid, exp_rw, exp_we;
        logic [3:0]  exp_reg;
        logic [15:0] exp_data, exp_addr;
    } vec_t;

    int   tests = 0;
    int   failed = 0;
    logic tmo_model = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what the stage should produce for one EX/MEM instruction
    function automatic vec_t model(input vec_t t);
        vec_t r = t;
        logic mem_op = t.v && (t.rd || t.wr);
        r.exp_valid = t.v;
        r.exp_rw    = t.v && t.rw;
        r.exp_reg   = t.v ? t.wreg : 4'd0;
        r.exp_we    = t.wr;
        r.exp_addr  = t.alu & 16'hFFFE;
        if (!t.v)                            r.exp_data = 16'h0000;
        else if (mem_op && t.rd && !t.wr && t.m2r) r.exp_data = t.rdata;
        else                                 r.exp_data = t.alu;
        return r;
    endfunction

    // Issue one instruction and respond to its memory access; called just after a posedge
    task automatic run_op(input vec_t t);
        logic ismem = t.v && (t.rd || t.wr);
        int   k = t.waits + 1;
        ex_valid = t.v; ex_memRead = t.rd; ex_memWrite = t.wr; ex_memToReg = t.m2r;
        ex_regWrite = t.rw; ex_writeReg = t.wreg; ex_aluOut = t.alu; ex_storeData = t.sd;
        mem_ready = 1'($urandom);      // ignored while idle
        mem_rdata = 16'($urandom);
        #1;
        chk("stall_accept", 16'(stall_o), 16'(ismem));
        chk("req_idle", 16'(mem_req), 16'h0);
        step();
        if (ismem) begin
            for (int j = 1; j <= k; j++) begin
                chk("req_busy", 16'(mem_req), 16'h1);
                chk("addr", mem_addr, t.exp_addr);
                chk("we", 16'(mem_we), 16'(t.exp_we));
                chk("wdata", mem_wdata, t.sd);
                chk("wb_bubble", 16'(wb_valid), 16'h0);
                chk("timeout_wait", 16'(mem_timeout), 16'(tmo_model || (j - 1) >= int'(TMO)));
                mem_ready = (j == k);
                mem_rdata = (j == k) ? t.rdata : 16'($urandom);
                #1;
                chk("stall_busy", 16'(stall_o), 16'(j < k));
                step();
            end
            tmo_model = tmo_model || (t.waits >= int'(TMO));
            chk("req_done", 16'(mem_req), 16'h0);
        end
        chk("wb_valid", 16'(wb_valid), 16'(t.exp_valid));
        chk("wb_regWrite", 16'(wb_regWrite), 16'(t.exp_rw));
        chk("wb_writeReg", 16'(wb_writeReg), 16'(t.exp_reg));
        chk("wb_data", wb_data, t.exp_data);
        chk("timeout", 16'(mem_timeout), 16'(tmo_model));
        mem_ready = 1'b0;
    endtask

    task automatic idle_cycle();
        ex_valid = 1'b0; ex_memRead = 1'b0; ex_memWrite = 1'b0;
        step();
    endtask

    vec_t tbl [7];
    vec_t r;

    initial begin
        //            v  rd wr m2r rw reg  alu       sd        rdata    w  eV eRW eWE eReg exp_data  exp_addr
        tbl[0] = '{1'b1,1'b0,1'b0,1'b0,1'b1,4'd5,16'h1234,16'h0000,16'h0000,0,1'b1,1'b1,1'b0,4'd5,16'h1234,16'h1234};
        tbl[1] = '{1'b0,1'b0,1'b0,1'b0,1'b1,4'd6,16'hFFFF,16'h0000,16'h0000,0,1'b0,1'b0,1'b0,4'd0,16'h0000,16'hFFFE};
        tbl[2] = '{1'b1,1'b0,1'b0,1'b0,1'b0,4'd3,16'h00FF,16'h0000,16'h0000,0,1'b1,1'b0,1'b0,4'd3,16'h00FF,16'h00FE};
        tbl[3] = '{1'b1,1'b1,1'b0,1'b1,1'b1,4'd7,16'h0041,16'h0000,16'hBEEF,2,1'b1,1'b1,1'b0,4'd7,16'hBEEF,16'h0040};
        tbl[4] = '{1'b1,1'b0,1'b1,1'b0,1'b0,4'd0,16'h0010,16'hCAFE,16'h0000,0,1'b1,1'b0,1'b1,4'd0,16'h0010,16'h0010};
        tbl[5] = '{1'b1,1'b1,1'b1,1'b1,1'b1,4'd2,16'h0022,16'h1111,16'hDEAD,1,1'b1,1'b1,1'b1,4'd2,16'h0022,16'h0022};
        tbl[6] = '{1'b1,1'b1,1'b0,1'b0,1'b1,4'd9,16'h0101,16'h0000,16'h5555,0,1'b1,1'b1,1'b0,4'd9,16'h0101,16'h0100};

        // Reset with live-looking inputs: every output stays 0
        rst_n = 1'b0; ex_valid = 1'b1; ex_memRead = 1'b0; ex_memWrite = 1'b0;
        ex_memToReg = 1'b0; ex_regWrite = 1'b1; ex_writeReg = 4'd5;
        ex_aluOut = 16'h1234; ex_storeData = 16'hAAAA; mem_ready = 1'b1; mem_rdata = 16'h7777;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", 16'(wb_valid), 16'h0);
        chk("rst_wb_rw", 16'(wb_regWrite), 16'h0);
        chk("rst_wb_reg", 16'(wb_writeReg), 16'h0);
        chk("rst_wb_data", wb_data, 16'h0);
        chk("rst_req", 16'(mem_req), 16'h0);
        chk("rst_we", 16'(mem_we), 16'h0);
        chk("rst_addr", mem_addr, 16'h0);
        chk("rst_wdata", mem_wdata, 16'h0);
        chk("rst_timeout", 16'(mem_timeout), 16'h0);
        chk("rst_stall", 16'(stall_o), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ex_valid = 1'b0;
        mem_ready = 1'b0;
        step();

        // Vector table, issued back to back
        foreach (tbl[i]) run_op(tbl[i]);
        idle_cycle();
        chk("single_wb_pulse", 16'(wb_valid), 16'h0);

        // Watchdog: ready withheld 6 cycles with TIMEOUT=4; load still completes
        r = '{1'b1,1'b1,1'b0,1'b1,1'b1,4'd4,16'h0081,16'h0000,16'h4242,6,1'b0,1'b0,1'b0,4'd0,16'h0,16'h0};
        run_op(model(r));
        idle_cycle();
        chk("timeout_sticky", 16'(mem_timeout), 16'h1);

        // Reset while BUSY drops mem_req without a clock edge
        ex_valid = 1'b1; ex_memRead = 1'b1; ex_memWrite = 1'b0; ex_aluOut = 16'h0200;
        step();
        chk("busy_req", 16'(mem_req), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("async_req_drop", 16'(mem_req), 16'h0);
        chk("async_timeout_clr", 16'(mem_timeout), 16'h0);
        ex_valid = 1'b0; ex_memRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tmo_model = 1'b0;
        step();
        chk("post_rst_wb", 16'(wb_valid), 16'h0);

        // Random operations against the model
        for (int n = 0; n < 40; n++) begin
            r.v     = ($urandom_range(0, 4) != 0);
            r.rd    = 1'($urandom);
            r.wr    = 1'($urandom);
            r.m2r   = 1'($urandom);
            r.rw    = 1'($urandom);
            r.wreg  = 4'($urandom);
            r.alu   = 16'($urandom);
            r.sd    = 16'($urandom);
            r.rdata = 16'($urandom);
            r.waits = $urandom_range(0, 6);
            run_op(model(r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
